// File: rtl/mips_ctrl_encoder.sv
// mips_ctrl_encoder: rebuilds MIPS instruction words from control bundles and streams them into instruction memory.
// Optional macro MIPS_FIELD_CHECK_EN additionally rejects bad R-type funct/rd and lw rt=0.
module mips_ctrl_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RegDst,
  input  logic              ALUSrc,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              Branch,
  input  logic              ALUOp1,
  input  logic              ALUOp0,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [5:0]        op_out,
  output logic              err,
  output logic              full,
  output logic [ADDR_W:0]   count
);
  localparam logic [1:0] IDLE = 2'd0, DECODE = 2'd1, WRITE = 2'd2, FULL = 2'd3;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);
  logic [1:0] state;
  logic [8:0] ctl;
  logic [4:0] rs_q, rt_q, rd_q;
  logic [5:0] funct_q, op;
  logic [15:0] imm_q;
  logic is_r, is_lw, is_sw, is_beq, bad, legal;
  logic [31:0] word;
  always_comb begin
    is_r = ctl == 9'b100100010;
    is_lw = ctl == 9'b011110000;
    is_sw = {ctl[7], ctl[5:0]} == 7'b1001000;
    is_beq = {ctl[7], ctl[5:0]} == 7'b0000101;
`ifdef MIPS_FIELD_CHECK_EN
    bad = (is_r && (!(funct_q inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) || rd_q == 5'd0))
        || (is_lw && rt_q == 5'd0);
`else
    bad = 1'b0;
`endif
    legal = (is_r || is_lw || is_sw || is_beq) && !bad;
    op = is_r ? 6'b000000 : is_lw ? 6'b100011 : is_sw ? 6'b101011 : 6'b000100;
    word = is_r ? {op, rs_q, rt_q, rd_q, 5'b0, funct_q} : {op, rs_q, rt_q, imm_q};
  end
  assign in_ready = state == IDLE && !reset;
  assign mem_we = state == WRITE && !clr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ctl <= '0;
      rs_q <= '0;
      rt_q <= '0;
      rd_q <= '0;
      funct_q <= '0;
      imm_q <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      op_out <= '0;
      err <= 1'b0;
      full <= 1'b0;
      count <= '0;
    end else if (clr) begin
      state <= IDLE;
      mem_addr <= '0;
      count <= '0;
      full <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state == IDLE && in_valid) begin
        ctl <= {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp1, ALUOp0};
        rs_q <= rs;
        rt_q <= rt;
        rd_q <= rd;
        funct_q <= funct;
        imm_q <= imm;
        state <= DECODE;
      end else if (state == DECODE) begin
        if (legal) begin
          op_out <= op;
          mem_wdata <= word;
        end
        err <= !legal;
        state <= legal ? WRITE : IDLE;
      end else if (state == WRITE) begin
        mem_addr <= mem_addr + 1'b1;
        count <= count + 1'b1;
        full <= count == LAST;
        state <= count == LAST ? FULL : IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mips_ctrl_encoder.sv
// tb_mips_ctrl_encoder: directed plus random bundles against a table-driven reference model (DEPTH=4).
module tb_mips_ctrl_encoder;
  localparam int AW = 2;
  localparam int DP = 4;
  localparam logic [8:0] MSK [4] = '{9'h1FF, 9'h1FF, 9'h0BF, 9'h0BF};
  localparam logic [8:0] VAL [4] = '{9'h122, 9'h0F0, 9'h088, 9'h005};
  localparam logic [5:0] OPS [4] = '{6'h00, 6'h23, 6'h2B, 6'h04};
  logic clk = 0, reset = 1, clr = 0, in_valid = 0;
  logic [8:0] b = '0;
  logic [4:0] rs = 0, rt = 0, rd = 0;
  logic [5:0] funct = 0;
  logic [15:0] imm = 0;
  logic in_ready, mem_we, err, full;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, last_word;
  logic [5:0] op_out;
  logic [AW:0] count;
  int checks = 0, errors = 0;
  int e_count = 0, e_addr = 0;
  logic e_full = 0;
  logic [31:0] e_wdata = 0;
  logic [5:0] e_op = 0;
  mips_ctrl_encoder #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .RegDst(b[8]), .ALUSrc(b[7]), .MemtoReg(b[6]), .RegWrite(b[5]), .MemRead(b[4]),
    .MemWrite(b[3]), .Branch(b[2]), .ALUOp1(b[1]), .ALUOp0(b[0]),
    .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .op_out(op_out),
    .err(err), .full(full), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] ref_op(input logic [8:0] c, input logic [4:0] t, input logic [4:0] d, input logic [5:0] f);
    logic [6:0] r = '0;
    for (int i = 0; i < 4; i++)
      if ((c & MSK[i]) == VAL[i]) r = {1'b1, OPS[i]};
`ifdef MIPS_FIELD_CHECK_EN
    if (r == 7'h40 && (!(f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) || d == 0)) r = '0;
    if (r == 7'h63 && t == 0) r = '0;
`endif
    return r;
  endfunction
  task automatic model_reset();
    e_count = 0; e_addr = 0; e_full = 0; e_wdata = 0; e_op = 0;
  endtask
  task automatic run(input logic [8:0] c, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                     input logic [5:0] f, input logic [15:0] im);
    logic [6:0] r;
    logic [31:0] w;
    r = ref_op(c, t, d, f);
    w = r[5:0] == 6'h00 ? {r[5:0], s, t, d, 5'b0, f} : {r[5:0], s, t, im};
    #1 chk("ready_idle", in_ready, 1);
    b = c; rs = s; rt = t; rd = d; funct = f; imm = im; in_valid = 1;
    @(posedge clk);
    @(negedge clk) in_valid = 0;
    chk("we_decode", mem_we, 0);
    chk("ready_decode", in_ready, 0);
    @(negedge clk);
    if (r[6]) begin
      chk("we_write", mem_we, 1);
      chk("addr_write", mem_addr, e_addr);
      chk("wdata", mem_wdata, w);
      chk("op_out", op_out, r[5:0]);
      chk("err_legal", err, 0);
      last_word = mem_wdata;
      e_wdata = w; e_op = r[5:0];
      e_count++; e_addr = (e_addr + 1) % (1 << AW); e_full = e_count == DP;
      @(negedge clk);
      chk("count", count, e_count);
      chk("full", full, e_full);
      chk("addr_next", mem_addr, e_addr);
      chk("we_after", mem_we, 0);
      chk("ready_after", in_ready, !e_full);
    end else begin
      chk("err_pulse", err, 1);
      chk("we_illegal", mem_we, 0);
      chk("wdata_keep", mem_wdata, e_wdata);
      chk("op_keep", op_out, e_op);
      chk("count_keep", count, e_count);
      @(negedge clk);
      chk("err_one_cycle", err, 0);
    end
  endtask
  task automatic do_clr();
    @(negedge clk) clr = 1;
    @(negedge clk) clr = 0;
    e_count = 0; e_addr = 0; e_full = 0;
    chk("clr_full", full, 0);
    chk("clr_addr", mem_addr, 0);
    chk("clr_count", count, 0);
    chk("clr_ready", in_ready, 1);
    chk("clr_wdata_keep", mem_wdata, e_wdata);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_op", op_out, 0);
    chk("rst_err", err, 0);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    reset = 0;
    run(9'h122, 1, 2, 3, 6'h20, 0);
    chk("lit_r", last_word, 32'h00221820);
    do_clr();
    run(9'h0F0, 4, 5, 0, 0, 16'h0010);
    chk("lit_lw", last_word, 32'h8C850010);
    run(9'h1C8, 4, 6, 0, 0, 16'h0014);
    chk("lit_sw", last_word, 32'hAC860014);
    run(9'h005, 1, 2, 0, 0, 16'hFFFF);
    chk("lit_beq", last_word, 32'h1022FFFF);
    run(9'h1FF, 7, 7, 7, 6'h3F, 16'h1234);
    run(9'h122, 1, 2, 3, 6'h00, 0);
    if (!e_full) run(9'h122, 1, 2, 3, 6'h22, 0);
    b = 9'h0F0; rt = 1; in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("full_ready", in_ready, 0);
      chk("full_we", mem_we, 0);
      chk("full_count", count, DP);
      chk("full_flag", full, 1);
    end
    in_valid = 0;
    do_clr();
    run(9'h0F0, 9, 10, 0, 0, 16'h0042);
    chk("addr_after_clr", e_addr, 1);
    b = 9'h122; rs = 1; rt = 2; rd = 3; funct = 6'h20; in_valid = 1;
    @(posedge clk);
    @(negedge clk) in_valid = 0;
    @(negedge clk);
    chk("we_pre_reset", mem_we, 1);
    #2 reset = 1;
    #1 chk("we_async_drop", mem_we, 0);
    chk("count_async", count, 0);
    chk("ready_in_reset", in_ready, 0);
    @(negedge clk) reset = 0;
    model_reset();
    for (int i = 0; i < 60; i++) begin
      logic [8:0] c;
      logic [5:0] f;
      int k;
      if (e_full || $urandom_range(0, 9) == 0) do_clr();
      k = $urandom_range(0, 4);
      c = k == 0 ? 9'h122 : k == 1 ? 9'h0F0 : k == 2 ? 9'h088 : k == 3 ? 9'h005 : 9'($urandom);
      if (k >= 2 && k <= 3) c = c | (9'($urandom) & 9'h140);
      f = $urandom_range(0, 1) ? 6'($urandom) : 6'h2A;
      run(c, 5'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), f, 16'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
